// File: rtl/decode_issue_stage.sv
// RV32I decode / operand-issue stage: decodes one instruction, resolves rs1/rs2 through
// prioritised forwarding sources, stalls on pending loads and issues over valid/ready.
module decode_issue_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_instr,
    input  logic                    flush_in,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [5*NUM_FWD-1:0]    fwd_addr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [5:0]              out_cmd,
    output logic [XLEN-1:0]         out_rs1_val,
    output logic [XLEN-1:0]         out_rs2_val,
    output logic [XLEN-1:0]         out_imm,
    output logic [4:0]              out_rd,
    output logic                    out_we,
    output logic                    out_illegal,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // Command codes shared with the execute stage; 0 marks an undecodable instruction.
    localparam logic [5:0] CmdNone   = 6'd0;
    localparam logic [5:0] CmdLUI    = 6'd1;
    localparam logic [5:0] CmdAUIPC  = 6'd2;
    localparam logic [5:0] CmdJAL    = 6'd3;
    localparam logic [5:0] CmdJALR   = 6'd4;
    localparam logic [5:0] CmdBEQ    = 6'd5;
    localparam logic [5:0] CmdBNE    = 6'd6;
    localparam logic [5:0] CmdBLT    = 6'd7;
    localparam logic [5:0] CmdBGE    = 6'd8;
    localparam logic [5:0] CmdBLTU   = 6'd9;
    localparam logic [5:0] CmdBGEU   = 6'd10;
    localparam logic [5:0] CmdLB     = 6'd11;
    localparam logic [5:0] CmdLH     = 6'd12;
    localparam logic [5:0] CmdLW     = 6'd13;
    localparam logic [5:0] CmdLBU    = 6'd14;
    localparam logic [5:0] CmdLHU    = 6'd15;
    localparam logic [5:0] CmdSB     = 6'd16;
    localparam logic [5:0] CmdSH     = 6'd17;
    localparam logic [5:0] CmdSW     = 6'd18;
    localparam logic [5:0] CmdADDI   = 6'd19;
    localparam logic [5:0] CmdSLTI   = 6'd20;
    localparam logic [5:0] CmdSLTIU  = 6'd21;
    localparam logic [5:0] CmdXORI   = 6'd22;
    localparam logic [5:0] CmdORI    = 6'd23;
    localparam logic [5:0] CmdANDI   = 6'd24;
    localparam logic [5:0] CmdSLLI   = 6'd25;
    localparam logic [5:0] CmdSRLI   = 6'd26;
    localparam logic [5:0] CmdSRAI   = 6'd27;
    localparam logic [5:0] CmdADD    = 6'd28;
    localparam logic [5:0] CmdSUB    = 6'd29;
    localparam logic [5:0] CmdSLL    = 6'd30;
    localparam logic [5:0] CmdSLT    = 6'd31;
    localparam logic [5:0] CmdSLTU   = 6'd32;
    localparam logic [5:0] CmdXOR    = 6'd33;
    localparam logic [5:0] CmdSRL    = 6'd34;
    localparam logic [5:0] CmdSRA    = 6'd35;
    localparam logic [5:0] CmdOR     = 6'd36;
    localparam logic [5:0] CmdAND    = 6'd37;
    localparam logic [5:0] CmdFENCE  = 6'd38;
    localparam logic [5:0] CmdECALL  = 6'd39;
    localparam logic [5:0] CmdEBREAK = 6'd40;

    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode   = in_instr[6:0];
    assign fun3     = in_instr[14:12];
    assign fun7     = in_instr[31:25];
    assign rd_f     = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
    assign imm_sh = {27'b0, in_instr[24:20]};

    logic [5:0]  dec_cmd;
    logic [31:0] dec_imm32;
    logic        dec_has_rd;
    logic        dec_use1;
    logic        dec_use2;
    logic        dec_legal;

    always_comb begin
        dec_cmd    = CmdNone;
        dec_imm32  = 32'b0;
        dec_has_rd = 1'b0;
        dec_use1   = 1'b0;
        dec_use2   = 1'b0;
        dec_legal  = 1'b1;
        case (opcode)
            OpLui: begin
                dec_cmd = CmdLUI; dec_imm32 = imm_u; dec_has_rd = 1'b1;
            end
            OpAuipc: begin
                dec_cmd = CmdAUIPC; dec_imm32 = imm_u; dec_has_rd = 1'b1;
            end
            OpJal: begin
                dec_cmd = CmdJAL; dec_imm32 = imm_j; dec_has_rd = 1'b1;
            end
            OpJalr: begin
                dec_cmd = CmdJALR; dec_imm32 = imm_i; dec_has_rd = 1'b1; dec_use1 = 1'b1;
                dec_legal = (fun3 == 3'd0);
            end
            OpBranch: begin
                dec_imm32 = imm_b; dec_use1 = 1'b1; dec_use2 = 1'b1;
                case (fun3)
                    3'd0:    dec_cmd = CmdBEQ;
                    3'd1:    dec_cmd = CmdBNE;
                    3'd4:    dec_cmd = CmdBLT;
                    3'd5:    dec_cmd = CmdBGE;
                    3'd6:    dec_cmd = CmdBLTU;
                    3'd7:    dec_cmd = CmdBGEU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpLoad: begin
                dec_imm32 = imm_i; dec_has_rd = 1'b1; dec_use1 = 1'b1;
                case (fun3)
                    3'd0:    dec_cmd = CmdLB;
                    3'd1:    dec_cmd = CmdLH;
                    3'd2:    dec_cmd = CmdLW;
                    3'd4:    dec_cmd = CmdLBU;
                    3'd5:    dec_cmd = CmdLHU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpStore: begin
                dec_imm32 = imm_s; dec_use1 = 1'b1; dec_use2 = 1'b1;
                case (fun3)
                    3'd0:    dec_cmd = CmdSB;
                    3'd1:    dec_cmd = CmdSH;
                    3'd2:    dec_cmd = CmdSW;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpImm: begin
                dec_imm32 = imm_i; dec_has_rd = 1'b1; dec_use1 = 1'b1;
                case (fun3)
                    3'd0: dec_cmd = CmdADDI;
                    3'd2: dec_cmd = CmdSLTI;
                    3'd3: dec_cmd = CmdSLTIU;
                    3'd4: dec_cmd = CmdXORI;
                    3'd6: dec_cmd = CmdORI;
                    3'd7: dec_cmd = CmdANDI;
                    3'd1: begin
                        dec_cmd = CmdSLLI; dec_imm32 = imm_sh;
                        dec_legal = (fun7 == 7'h00);
                    end
                    default: begin
                        dec_imm32 = imm_sh;
                        if (fun7 == 7'h00)      dec_cmd = CmdSRLI;
                        else if (fun7 == 7'h20) dec_cmd = CmdSRAI;
                        else                    dec_legal = 1'b0;
                    end
                endcase
            end
            OpReg: begin
                dec_has_rd = 1'b1; dec_use1 = 1'b1; dec_use2 = 1'b1;
                if (fun7 == 7'h00) begin
                    case (fun3)
                        3'd0:    dec_cmd = CmdADD;
                        3'd1:    dec_cmd = CmdSLL;
                        3'd2:    dec_cmd = CmdSLT;
                        3'd3:    dec_cmd = CmdSLTU;
                        3'd4:    dec_cmd = CmdXOR;
                        3'd5:    dec_cmd = CmdSRL;
                        3'd6:    dec_cmd = CmdOR;
                        default: dec_cmd = CmdAND;
                    endcase
                end else if (fun7 == 7'h20 && fun3 == 3'd0) begin
                    dec_cmd = CmdSUB;
                end else if (fun7 == 7'h20 && fun3 == 3'd5) begin
                    dec_cmd = CmdSRA;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OpFence: begin
                dec_cmd = CmdFENCE; dec_imm32 = imm_i;
                dec_legal = (fun3 == 3'd0);
            end
            OpSystem: begin
                if (in_instr == 32'h0000_0073)      dec_cmd = CmdECALL;
                else if (in_instr == 32'h0010_0073) dec_cmd = CmdEBREAK;
                else                                dec_legal = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
        // An illegal op issues as an inert bubble: no operands, no writeback.
        if (!dec_legal) begin
            dec_cmd    = CmdNone;
            dec_imm32  = 32'b0;
            dec_has_rd = 1'b0;
            dec_use1   = 1'b0;
            dec_use2   = 1'b0;
        end
    end

    // Returns {hazard, value}; the youngest matching source wins even if it is still pending.
    function automatic logic [XLEN:0] resolve(input logic [4:0]              rs,
                                              input logic                    used,
                                              input logic [XLEN-1:0]         rf,
                                              input logic [NUM_FWD-1:0]      fv,
                                              input logic [NUM_FWD-1:0]      fp,
                                              input logic [5*NUM_FWD-1:0]    fa,
                                              input logic [XLEN*NUM_FWD-1:0] fd);
        logic            found;
        logic            haz;
        logic [XLEN-1:0] val;
        found = 1'b0;
        haz   = 1'b0;
        val   = rf;
        if (!used || rs == 5'd0) begin
            val = '0;
        end else begin
            for (int i = 0; i < int'(NUM_FWD); i++) begin
                if (!found && fv[i] && fa[5*i +: 5] == rs) begin
                    found = 1'b1;
                    haz   = fp[i];
                    val   = fd[XLEN*i +: XLEN];
                end
            end
        end
        return {haz, val};
    endfunction

    logic            haz1, haz2, hazard, accept;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign {haz1, rs1_val} = resolve(rs1_addr, dec_use1, rs1_data, fwd_valid, fwd_pending,
                                     fwd_addr, fwd_data);
    assign {haz2, rs2_val} = resolve(rs2_addr, dec_use2, rs2_data, fwd_valid, fwd_pending,
                                     fwd_addr, fwd_data);
    assign hazard = haz1 | haz2;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [5:0]      out_cmd_q, out_cmd_d;
    logic [XLEN-1:0] out_rs1_q, out_rs1_d;
    logic [XLEN-1:0] out_rs2_q, out_rs2_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_we_q, out_we_d;
    logic            out_ill_q, out_ill_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign in_ready = !rst_in && rdy_in && !flush_in && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_cmd_d   = out_cmd_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        out_ill_d   = out_ill_q;
        if (flush_in) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            out_cmd_d   = dec_cmd;
            out_rs1_d   = rs1_val;
            out_rs2_d   = rs2_val;
            out_imm_d   = XLEN'(signed'(dec_imm32));
            out_rd_d    = dec_has_rd ? rd_f : 5'd0;
            out_we_d    = dec_has_rd && (rd_f != 5'd0);
            out_ill_d   = !dec_legal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        stall_d = stall_q;
        if (in_valid && hazard && !flush_in && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_cmd_q   <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            out_ill_q   <= 1'b0;
            stall_q     <= '0;
        end else if (rdy_in) begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_cmd_q   <= out_cmd_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_imm_q   <= out_imm_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
            out_ill_q   <= out_ill_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_cmd     = out_cmd_q;
    assign out_rs1_val = out_rs1_q;
    assign out_rs2_val = out_rs2_q;
    assign out_imm     = out_imm_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign out_illegal = out_ill_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a decode/forwarding vector table plus hand-written
// sequences for reset, load-use stall, backpressure, flush, freeze and counter saturation.
module tb_decode_issue_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_FWD = 2;
    localparam int unsigned CW      = 4;

    localparam logic [5:0] CmdLUI = 6'd1, CmdAUIPC = 6'd2, CmdJAL = 6'd3, CmdJALR = 6'd4;
    localparam logic [5:0] CmdBEQ = 6'd5, CmdLBU = 6'd14, CmdSW = 6'd18, CmdADDI = 6'd19;
    localparam logic [5:0] CmdSRLI = 6'd26, CmdSRAI = 6'd27, CmdADD = 6'd28, CmdSUB = 6'd29;

    logic            clk = 1'b0;
    logic            rst, rdy, in_valid, in_ready, flush, out_valid, out_ready, out_we, out_ill;
    logic [31:0]     in_pc, in_instr, rs1_data, rs2_data, out_pc, out_rs1, out_rs2, out_imm;
    logic [4:0]      rs1_addr, rs2_addr, out_rd;
    logic [1:0]      fwd_valid, fwd_pending;
    logic [9:0]      fwd_addr;
    logic [63:0]     fwd_data;
    logic [5:0]      out_cmd;
    logic [CW-1:0]   stall_cnt;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CW)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush_in(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_cmd(out_cmd), .out_rs1_val(out_rs1), .out_rs2_val(out_rs2), .out_imm(out_imm),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_ill), .stall_cnt(stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rf1, rf2;
        logic [1:0]  fv;
        logic [4:0]  fa0, fa1;
        logic [31:0] fd0, fd1;
        logic [5:0]  cmd;
        logic [31:0] v1, v2, imm;
        logic [4:0]  rd;
        logic        we, ill, chk_imm;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // instr, rf1, rf2, fv, fa0, fa1, fd0, fd1, cmd, v1, v2, imm, rd, we, ill, chk_imm
        vecs[0]  = '{32'h00500093, 32'h11, 32'h22, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdADDI, 32'h0, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h002081B3, 32'h99, 32'h7, 2'b11, 5'd1, 5'd1, 32'hAA, 32'hBB,
                     CmdADD, 32'hAA, 32'h7, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h407302B3, 32'h66, 32'h77, 2'b10, 5'd0, 5'd7, 32'h0, 32'h1234,
                     CmdSUB, 32'h66, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h40325213, 32'h80000000, 32'h5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdSRAI, 32'h80000000, 32'h0, 32'h3, 5'd4, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h00325213, 32'h8, 32'h5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdSRLI, 32'h8, 32'h0, 32'h3, 5'd4, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'hFE20AE23, 32'h1000, 32'hDEAD, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdSW, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'hFE208CE3, 32'h5, 32'h5, 2'b01, 5'd2, 5'd0, 32'h42, 32'h0,
                     CmdBEQ, 32'h5, 32'h42, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h12345537, 32'hFFFF, 32'hFFFF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdLUI, 32'h0, 32'h0, 32'h12345000, 5'd10, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h001000EF, 32'h1, 32'h2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdJAL, 32'h0, 32'h0, 32'h800, 5'd1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h00008067, 32'h300, 32'h2, 2'b10, 5'd0, 5'd1, 32'h0, 32'h444,
                     CmdJALR, 32'h444, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'hFFF14283, 32'h20, 32'h2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdLBU, 32'h20, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'hFFFFFFFF, 32'h1, 32'h2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     6'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h022081B3, 32'h1, 32'h2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     6'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{32'h00001117, 32'h1, 32'h2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     CmdAUIPC, 32'h0, 32'h0, 32'h1000, 5'd2, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h00500093;
        rs1_data = '0; rs2_data = '0; fwd_valid = '0; fwd_pending = '0;
        fwd_addr = '0; fwd_data = '0;

        // Reset held two cycles with a valid instruction presented.
        repeat (2) begin
            @(negedge clk);
            check("reset in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk); #1;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out_pc", out_pc, 32'h0);
        check("reset out_cmd", 32'(out_cmd), 32'h0);
        check("reset out_rs1", out_rs1, 32'h0);
        check("reset out_rs2", out_rs2, 32'h0);
        check("reset out_imm", out_imm, 32'h0);
        check("reset out_rd", 32'(out_rd), 32'h0);
        check("reset out_we", 32'(out_we), 32'h0);
        check("reset out_ill", 32'(out_ill), 32'h0);
        check("reset stall_cnt", 32'(stall_cnt), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pc = 32'h100 + 32'(4 * i);
            in_instr = vecs[i].instr;
            rs1_data = vecs[i].rf1;
            rs2_data = vecs[i].rf2;
            fwd_valid = vecs[i].fv;
            fwd_pending = 2'b00;
            fwd_addr = {vecs[i].fa1, vecs[i].fa0};
            fwd_data = {vecs[i].fd1, vecs[i].fd0};
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'h1);
            check($sformatf("v%0d rs1_addr", i), 32'(rs1_addr), 32'(vecs[i].instr[19:15]));
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
            check($sformatf("v%0d out_pc", i), out_pc, 32'h100 + 32'(4 * i));
            check($sformatf("v%0d out_cmd", i), 32'(out_cmd), 32'(vecs[i].cmd));
            check($sformatf("v%0d out_we", i), 32'(out_we), 32'(vecs[i].we));
            check($sformatf("v%0d out_ill", i), 32'(out_ill), 32'(vecs[i].ill));
            if (!vecs[i].ill) begin
                check($sformatf("v%0d out_rs1", i), out_rs1, vecs[i].v1);
                check($sformatf("v%0d out_rs2", i), out_rs2, vecs[i].v2);
            end
            if (vecs[i].chk_imm) check($sformatf("v%0d out_imm", i), out_imm, vecs[i].imm);
            if (vecs[i].we) check($sformatf("v%0d out_rd", i), 32'(out_rd), 32'(vecs[i].rd));
        end
        @(negedge clk);
        in_valid = 1'b0; fwd_valid = '0;

        // Load-use: youngest source pending on x1 blocks an older ready match.
        @(negedge clk);
        check("pre-lu out_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'h002081B3;
        rs1_data = 32'h99; rs2_data = 32'h7;
        fwd_valid = 2'b11; fwd_pending = 2'b01;
        fwd_addr = {5'd1, 5'd1}; fwd_data = {32'hBB, 32'h0};
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("lu in_ready c%0d", k), 32'(in_ready), 32'h0);
            @(negedge clk);
            check($sformatf("lu out_valid c%0d", k), 32'(out_valid), 32'h0);
        end
        fwd_pending = 2'b00; fwd_data = {32'hBB, 32'h55};
        #1;
        check("lu stall_cnt", 32'(stall_cnt), 32'h3);
        check("lu release in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        check("lu out_valid", 32'(out_valid), 32'h1);
        check("lu out_rs1", out_rs1, 32'h55);
        check("lu out_rs2", out_rs2, 32'h7);
        check("lu out_cmd", 32'(out_cmd), 32'(CmdADD));
        check("lu stall_cnt after", 32'(stall_cnt), 32'h3);

        // Drain, then backpressure with a second instruction waiting.
        @(negedge clk);
        in_valid = 1'b0; fwd_valid = '0; out_ready = 1'b1;
        @(negedge clk);
        check("drain out_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h00500093; out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp first out_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        in_pc = 32'h404; in_instr = 32'h12345537;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp in_ready c%0d", k), 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            check($sformatf("bp out_valid c%0d", k), 32'(out_valid), 32'h1);
            check($sformatf("bp out_pc c%0d", k), out_pc, 32'h400);
            check($sformatf("bp out_imm c%0d", k), out_imm, 32'h5);
            check($sformatf("bp out_cmd c%0d", k), 32'(out_cmd), 32'(CmdADDI));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        check("bp next out_valid", 32'(out_valid), 32'h1);
        check("bp next out_pc", out_pc, 32'h404);
        check("bp next out_imm", out_imm, 32'h12345000);
        check("bp next out_cmd", 32'(out_cmd), 32'(CmdLUI));
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp drained out_valid", 32'(out_valid), 32'h0);

        // Flush beats a same-cycle accept, and kills a held op.
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h00500093; flush = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        check("flush accept out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("flush held out_valid pre", 32'(out_valid), 32'h1);
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("flush held out_valid", 32'(out_valid), 32'h0);

        // rdy_in low freezes everything, including the stall counter.
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'h00001117;
        out_ready = 1'b1;
        @(negedge clk);
        check("frz out_valid pre", 32'(out_valid), 32'h1);
        rdy = 1'b0; in_pc = 32'h604; in_instr = 32'h002081B3;
        fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd1};
        #1;
        check("frz in_ready", 32'(in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("frz out_valid", 32'(out_valid), 32'h1);
        check("frz out_pc", out_pc, 32'h600);
        check("frz out_cmd", 32'(out_cmd), 32'(CmdAUIPC));
        check("frz stall_cnt", 32'(stall_cnt), 32'h3);

        // Saturation: 12 hazard cycles take the 4-bit counter from 3 to 15, then it holds.
        @(negedge clk);
        rdy = 1'b1;
        repeat (12) @(negedge clk);
        check("sat stall_cnt 15", 32'(stall_cnt), 32'hF);
        check("sat out_valid drained", 32'(out_valid), 32'h0);
        repeat (5) @(negedge clk);
        check("sat stall_cnt hold", 32'(stall_cnt), 32'hF);
        in_valid = 1'b0; fwd_valid = '0; fwd_pending = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered RV32I decode/operand-issue stage for the 2021 CPU pipeline; sits between the IF/ID latch and the ID/EX boundary.
- Decodes the instruction and reads rs1/rs2 from the regfile.
- Resolves operands through NUM_FWD prioritised forwarding sources.
- Detects load-use (pending-data) hazards and issues one decoded op per cycle over a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, data/address width.
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; when low, all state is frozen.
- in_valid  in  1  instruction available from IF/ID.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_instr  in  32  instruction word.
- flush_in  in  1  branch/jump mispredict kill.
- rs1_addr, rs2_addr  out  5 each  combinational regfile read addresses.
- rs1_data, rs2_data  in  XLEN each  regfile read data, same cycle.
- fwd_valid  in  NUM_FWD  source i holds a register write.
- fwd_pending  in  NUM_FWD  source i's data is not yet available (load in flight).
- fwd_addr  in  5*NUM_FWD  destination register, packed; source i at [5i+4:5i].
- fwd_data  in  XLEN*NUM_FWD  forward data, packed.
- out_valid  out  1  decoded op valid.
- out_ready  in  1  EX accepts the op.
- out_pc  out  XLEN  PC.
- out_cmd  out  6  command code per the shared command-type defines.
- out_rs1_val, out_rs2_val  out  XLEN each  resolved operands.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable.
- out_illegal  out  1  undecodable instruction.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (synchronous, rst_in=1 at a clock edge): every output register and stall_cnt go to 0. in_ready is combinational, so it reads 0 only while rst_in is high.
- Decode and immediates:
  - Immediates are formed for U/J/B/I/S types; SLLI/SRLI/SRAI use zero-extended shamt [24:20].
  - ADD decodes to CmdADD, SUB to CmdSUB, SRL/SRA to CmdSRL/CmdSRA, SRLI/SRAI to CmdSRLI/CmdSRAI.
  - Unknown opcode, fun3 or fun7: out_cmd=0, out_we=0, out_illegal=1. The op still issues.
  - rd=0 forces out_we=0.
- Operand resolution (per rs, only when the format reads that rs):
  - Address 0, or rs not used by the format → value 0.
  - Otherwise take the lowest i with fwd_valid[i] && fwd_addr[i]==rs.
  - If that source is pending → hazard. Otherwise use fwd_data[i].
  - No matching source → regfile data.
  - A pending match at a lower index blocks older non-pending matches.
- Handshake:
  - in_ready = rdy_in & !flush_in & !hazard & (!out_valid | out_ready).
  - Accept = in_valid & in_ready. On accept, all output fields register on the next edge and out_valid←1.
  - If out_valid & out_ready & !accept, then out_valid←0.
  - While out_valid=1 & out_ready=0, every output field stays bit-stable.
  - Latency is one cycle from accept to out_valid.
- Flush: out_valid←0 at the next edge. No instruction is accepted in the flush cycle. Flush overrides an accept in the same cycle.
- stall_cnt: increments each cycle where rdy_in & in_valid & hazard & !flush_in. Saturates at all-ones and is never cleared except by reset.
- rdy_in=0: no register changes and in_ready=0; rst_in still takes effect.

Test Plan:
- Reset: assert rst_in for 2 cycles with in_valid=1 → out_valid=0, out_* all 0, stall_cnt=0.
- Basic issue: ADDI x1,x0,5 (0x00500093), pc 0x100, out_ready=1 → next cycle out_valid=1, out_pc=0x100, out_rd=1, out_imm=5, out_rs1_val=0, out_we=1.
- Forward priority: ADD x3,x1,x2 (0x002081B3); fwd0={x1,0xAA}, fwd1={x1,0xBB}, regfile x2=7 → out_rs1_val=0xAA, out_rs2_val=7, out_cmd=CmdADD.
- Load-use: same ADD with fwd0 pending on x1 for 3 cycles, then pending=0 and data 0x55 → in_ready=0 for 3 cycles, stall_cnt=3, then issues with out_rs1_val=0x55.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with a new in_valid → outputs unchanged and in_ready=0. Release → the held op completes and the new op issues the next cycle.
- Flush and illegal: flush_in together with an accepted instruction → out_valid=0 next cycle. Separately, instruction 0xFFFFFFFF → out_illegal=1, out_we=0, out_cmd=0.
